fwd_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forwarding mux.
- Keeps an internal shift-register scoreboard of in-flight register writes (address, write-enable, Tnew) for NSTAGE stages after decode.
- Resolves operand forwarding for NREAD decode-stage read ports and produces the decode stall.
- Sits between the decode register-file reads and the E/M/W/... pipeline registers; the datapath supplies the per-stage write data.

---
 rtl/fwd_scoreboard.sv | 110 +++++++++++
 tb/tb_fwd_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writes for NSTAGE stages after
// decode and resolves per-port operand forwarding plus the decode stall.
// Youngest matching write wins; register 0 is never forwarded nor stalled on.
module fwd_scoreboard #(
  parameter int NREAD  = 2,
  parameter int NSTAGE = 4,
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int SW     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [AW-1:0]         issue_ad,
  input  logic [TW-1:0]         issue_tnew,
  input  logic [NREAD*AW-1:0]   rd_ad,
  input  logic [NREAD*TW-1:0]   rd_tuse,
  input  logic [NREAD*DW-1:0]   rd_default,
  input  logic [NSTAGE*DW-1:0]  stage_wd,
  output logic [NREAD*DW-1:0]   rd_data,
  output logic [NREAD*SW-1:0]   fwd_sel,
  output logic                  stall,
  output logic [31:0]           stall_cnt
);

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] ad;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t [NSTAGE-1:0] sb_q, sb_d;
  logic   [31:0]       stall_cnt_q, stall_cnt_d;
  logic   [NREAD-1:0]  port_stall;

  // Per-port forwarding resolution against the youngest matching entry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loops below leaves a variable unassigned (no latches).
    rd_data    = rd_default;
    fwd_sel    = '0;
    port_stall = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic found;
      found = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && sb_q[k].v && sb_q[k].we &&
            sb_q[k].ad == rd_ad[i*AW +: AW] && rd_ad[i*AW +: AW] != '0) begin
          found = 1'b1;
          if (sb_q[k].tnew == '0) begin
            rd_data[i*DW +: DW] = stage_wd[k*DW +: DW];
            fwd_sel[i*SW +: SW] = SW'(k + 1);
          end else if (sb_q[k].tnew > rd_tuse[i*TW +: TW]) begin
            port_stall[i] = 1'b1;
          end
          // tnew in (0, tuse]: read the register file now; a later-stage
          // forward supplies the value once it exists, older matches are stale.
        end
      end
    end
    stall = |port_stall;
  end

  // Next scoreboard state: issue or bubble into entry 0, age the rest.
  always_comb begin
    if (issue_valid && !stall) begin
      sb_d[0] = '{v: 1'b1, we: issue_we, ad: issue_ad, tnew: issue_tnew};
    end else begin
      sb_d[0] = '0;
    end
    for (int k = 1; k < NSTAGE; k++) begin
      sb_d[k] = sb_q[k-1];
      if (sb_q[k-1].tnew != '0) begin
        sb_d[k].tnew = sb_q[k-1].tnew - TW'(1);
      end
    end
    // Flush beats a simultaneous issue.
    if (flush) begin
      sb_d = '0;
    end
  end

  // Saturating stall-cycle counter; flush does not touch it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers; reset clears the scoreboard, dropping stall at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: stimulus pushes hand-computed expected
// outputs into a queue, a monitor pops and compares when told to sample.
module tb_fwd_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         issue_valid;
  logic         issue_we;
  logic [4:0]   issue_ad;
  logic [1:0]   issue_tnew;
  logic [9:0]   rd_ad;
  logic [3:0]   rd_tuse;
  logic [63:0]  rd_default;
  logic [127:0] stage_wd;
  logic [63:0]  rd_data;
  logic [5:0]   fwd_sel;
  logic         stall;
  logic [31:0]  stall_cnt;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  fwd;
    logic        stall;
    logic [31:0] cnt;
    logic        full;   // also compare rd_data/fwd_sel
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  chk_ev;
  int    n_checks = 0;
  int    n_errors = 0;
  logic [31:0] sv [4];

  fwd_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_we   (issue_we),
    .issue_ad   (issue_ad),
    .issue_tnew (issue_tnew),
    .rd_ad      (rd_ad),
    .rd_tuse    (rd_tuse),
    .rd_default (rd_default),
    .stage_wd   (stage_wd),
    .rd_data    (rd_data),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue an expectation and ask the monitor to sample now.
  task automatic expect_out(input string name, input logic [63:0] d, input logic [5:0] f,
                            input logic s, input logic [31:0] c, input logic full);
    exp_t e;
    e.data = d; e.fwd = f; e.stall = s; e.cnt = c; e.full = full;
    exp_q.push_back(e);
    name_q.push_back(name);
    ->chk_ev;
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] ad, input logic [1:0] tn);
    issue_valid = 1'b1;
    issue_we    = we;
    issue_ad    = ad;
    issue_tnew  = tn;
  endtask

  task automatic drain(input int n);
    issue_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one expectation per sample request and compares.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        check("monitor_underflow", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".stall"}, {63'd0, stall}, {63'd0, e.stall});
        check({nm, ".stall_cnt"}, {32'd0, stall_cnt}, {32'd0, e.cnt});
        if (e.full) begin
          check({nm, ".rd_data"}, rd_data, e.data);
          check({nm, ".fwd_sel"}, {58'd0, fwd_sel}, {58'd0, e.fwd});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sv[0] = 32'h1234; sv[1] = 32'h5678; sv[2] = 32'h9ABC; sv[3] = 32'hDEF0;
    reset = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_ad = '0; issue_tnew = '0;
    rd_ad      = {5'd6, 5'd5};
    rd_tuse    = '0;
    rd_default = {32'hB, 32'hA};
    stage_wd   = {sv[3], sv[2], sv[1], sv[0]};

    #2 expect_out("reset", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk); reset = 1'b0;

    // tnew=0 write to r5 forwarded from each stage in turn, then retired.
    @(negedge clk); issue(1'b1, 5'd5, 2'd0);
    @(negedge clk); issue_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("fwd_stage%0d", k), {32'hB, sv[k]}, {3'd0, 3'(k + 1)},
                 1'b0, 32'd0, 1'b1);
      @(negedge clk);
    end
    expect_out("fwd_retired", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd0, 1'b1);

    // Load-use: r7 tnew=2 read on port 1 with tuse=0.
    @(negedge clk); rd_ad = {5'd7, 5'd5}; issue(1'b1, 5'd7, 2'd2);
    @(negedge clk); issue_valid = 1'b0;
    expect_out("lu_c1", '0, '0, 1'b1, 32'd0, 1'b0);
    @(negedge clk);
    expect_out("lu_c2", '0, '0, 1'b1, 32'd1, 1'b0);
    @(negedge clk);
    expect_out("lu_c3", {32'h9ABC, 32'hA}, {3'd3, 3'd0}, 1'b0, 32'd2, 1'b1);
    drain(3);

    // tnew == tuse: no stall, register file now, stage-1 forward next cycle.
    rd_tuse = {2'd1, 2'd0}; issue(1'b1, 5'd7, 2'd1);
    @(negedge clk); issue_valid = 1'b0;
    expect_out("tuse_eq", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd2, 1'b1);
    @(negedge clk);
    expect_out("tuse_fwd", {32'h5678, 32'hA}, {3'd2, 3'd0}, 1'b0, 32'd2, 1'b1);
    drain(4);
    rd_tuse = '0;

    // Two writers to r3: the younger one (stage 0) wins.
    rd_ad = {5'd6, 5'd3};
    stage_wd = {sv[3], sv[2], 32'h11, 32'h22};
    issue(1'b1, 5'd3, 2'd0);
    @(negedge clk); issue(1'b1, 5'd3, 2'd0);
    @(negedge clk); issue_valid = 1'b0;
    expect_out("youngest", {32'hB, 32'h22}, {3'd0, 3'd1}, 1'b0, 32'd2, 1'b1);
    drain(4);

    // Write to r0 with a long tnew: never forwards, never stalls.
    rd_ad = {5'd6, 5'd0};
    issue(1'b1, 5'd0, 2'd3);
    @(negedge clk); issue_valid = 1'b0;
    expect_out("r0", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd2, 1'b1);
    drain(4);

    // Flush a pending tnew=2 entry; the stalled edge still counts.
    rd_ad = {5'd9, 5'd5};
    issue(1'b1, 5'd9, 2'd2);
    @(negedge clk); issue_valid = 1'b0;
    expect_out("flush_pre", '0, '0, 1'b1, 32'd2, 1'b0);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    expect_out("flush_post", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd3, 1'b1);

    // Flush together with an issue: the issue is dropped.
    @(negedge clk); flush = 1'b1; issue(1'b1, 5'd9, 2'd0);
    @(negedge clk); flush = 1'b0; issue_valid = 1'b0;
    expect_out("flush_wins", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd3, 1'b1);

    // Reset asserted mid-stall drops stall without a clock edge.
    @(negedge clk); issue(1'b1, 5'd9, 2'd2);
    @(negedge clk); issue_valid = 1'b0;
    expect_out("rst_pre", '0, '0, 1'b1, 32'd3, 1'b0);
    #1 reset = 1'b1;
    #1 expect_out("rst_async", {32'hB, 32'hA}, 6'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk); reset = 1'b0;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) #1;
    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
